// File: rtl/mc_mem_pkg.sv
// Shared types and constants for the unified instruction/data memory.
package mc_mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic [BE_W-1:0] BE_FULL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Operands captured when a request is accepted
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } mem_req_t;

endpackage

// File: rtl/mc_mem_array.sv
// Synchronous single-port word RAM with per-byte write enables.
module mc_mem_array
  import mc_mem_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned IDX_W     = $clog2(DEPTH),
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  idx,
  input  logic [BE_W-1:0]   wen,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] q
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (wen[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
    q <= mem[idx];
  end

endmodule

// File: rtl/mc_unified_memory.sv
// Unified I/D memory for the multicycle core: one word access per request,
// fixed wait latency, registered ready/rdata/err/busy.
module mc_unified_memory
  import mc_mem_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter string       INIT_FILE = "memfile.mem"
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic              ready,
  output logic [WORD_W-1:0] rdata,
  output logic              busy,
  output logic              err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  mem_req_t          op;
  logic              fault_c;
  logic              wr_en_c;
  logic [IDX_W-1:0]  idx_c;
  logic [BE_W-1:0]   wen_c;
  logic [WORD_W-1:0] ram_q;

  // Misaligned, out of range, or no byte lanes selected
  always_comb begin
    fault_c = 1'b0;
    if (op.addr[1:0] != 2'b00)             fault_c = 1'b1;
    if (op.addr[ADDR_W-1:IDX_W+2] != '0)   fault_c = 1'b1;
    if (op.be == '0)                       fault_c = 1'b1;
  end

  // RAM reads the incoming address while idle so data is ready even at LATENCY=1
  always_comb begin
    idx_c   = (state == IDLE) ? addr[IDX_W+1:2] : op.addr[IDX_W+1:2];
    wr_en_c = (state == RESP) && op.we && !fault_c && !RST;
    wen_c   = {BE_W{wr_en_c}} & op.be;
  end

  mc_mem_array #(
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk   (CLK),
    .idx   (idx_c),
    .wen   (wen_c),
    .wdata (op.wdata),
    .q     (ram_q)
  );

  always_ff @(posedge CLK) begin
    if (state == IDLE && req) op <= '{we: we, addr: addr, wdata: wdata, be: be};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      ready <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (req) begin
            busy  <= 1'b1;
            cnt   <= CNT_W'(LATENCY - 1);
            state <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= RESP;
        end
        RESP: begin
          ready <= 1'b1;
          busy  <= 1'b1;
          err   <= fault_c;
          if (fault_c)      rdata <= '0;
          else if (!op.we)  rdata <= ram_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
